// File: rtl/dshot150_frame_encoder.sv
// DSHOT150 frame encoder: builds {throttle, telem, crc}, serialises it MSB first
// with per-bit high-time coding, enforces an inter-frame gap and optionally auto-repeats.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line low, ready for a command; fires a repeat when the period elapses
// HIGH   | inside a bit period, line high (pulse portion)
// LOW    | inside a bit period, line low (remainder of the period)
// GAP    | line held low for GAP_CLKS after the last bit
module dshot150_frame_encoder #(
    parameter int BIT_CLKS    = 480,
    parameter int T1H_CLKS    = 360,
    parameter int T0H_CLKS    = 180,
    parameter int GAP_CLKS    = 960,
    parameter int REPEAT_CLKS = 72000
) (
    input  logic        i_sys_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [10:0] i_throttle,
    input  logic        i_telem,
    output logic        o_dshot,
    output logic        o_busy,
    output logic [15:0] o_frame,
    output logic        o_frame_done
);

    localparam int MAX_A    = (REPEAT_CLKS > GAP_CLKS) ? REPEAT_CLKS : GAP_CLKS;
    localparam int MAX_CLKS = (MAX_A > BIT_CLKS) ? MAX_A : BIT_CLKS;
    localparam int CW       = $clog2(MAX_CLKS + 1);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CLKS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CLKS > 0) ? REPEAT_CLKS - 1 : 0);
    localparam logic [CW-1:0] T1H       = CW'(T1H_CLKS);
    localparam logic [CW-1:0] T0H       = CW'(T0H_CLKS);
    localparam bit            REPEAT_EN = (REPEAT_CLKS > 0);

    // Every bit starts with a high phase, so a zero-length '0' pulse is not allowed.
    generate
        if (!(T0H_CLKS > 0 && T0H_CLKS < T1H_CLKS && T1H_CLKS < BIT_CLKS && GAP_CLKS > 0))
        begin : g_param_check
            $error("dshot150_frame_encoder: need 0 < T0H_CLKS < T1H_CLKS < BIT_CLKS and GAP_CLKS > 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] per_cnt_q, per_cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   frame_q, frame_d;
    logic          armed_q, armed_d;
    logic          dshot_q, dshot_d;
    logic          done_q, done_d;

    logic [11:0]   cmd_v;
    logic [3:0]    cmd_crc;
    logic [15:0]   cmd_frame;
    logic          accept;
    logic          repeat_due;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] high_thr;

    assign cmd_v      = {i_throttle, i_telem};
    assign cmd_crc    = cmd_v[3:0] ^ cmd_v[7:4] ^ cmd_v[11:8];
    assign cmd_frame  = {cmd_v, cmd_crc};

    assign accept     = i_valid && (state_q == S_IDLE);
    assign repeat_due = REPEAT_EN && armed_q && (per_cnt_q >= REP_LAST);
    assign cnt_inc    = cnt_q + ONE;
    assign high_thr   = shift_q[15] ? T1H : T0H;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_cnt_d = per_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        frame_d   = frame_q;
        armed_d   = armed_q;
        dshot_d   = 1'b0;
        done_d    = 1'b0;

        // Period counter free-runs and saturates; a frame start below clears it.
        if (per_cnt_q < REP_LAST) begin
            per_cnt_d = per_cnt_q + ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept || repeat_due) begin
                    if (accept) begin
                        frame_d = cmd_frame;
                        shift_d = cmd_frame;
                        armed_d = REPEAT_EN;
                    end else begin
                        shift_d = frame_q;
                    end
                    state_d   = S_HIGH;
                    cnt_d     = '0;
                    bit_idx_d = 4'd15;
                    per_cnt_d = '0;
                    dshot_d   = 1'b1;
                end
            end

            S_HIGH, S_LOW: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 4'd0) begin
                        state_d = S_GAP;
                        done_d  = 1'b1;
                    end else begin
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_idx_d = bit_idx_q - 4'd1;
                        state_d   = S_HIGH;
                        dshot_d   = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    dshot_d = (cnt_inc < high_thr);
                    state_d = (cnt_inc < high_thr) ? S_HIGH : S_LOW;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            per_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            frame_q   <= '0;
            armed_q   <= 1'b0;
            dshot_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_cnt_q <= per_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            frame_q   <= frame_d;
            armed_q   <= armed_d;
            dshot_q   <= dshot_d;
            done_q    <= done_d;
        end
    end

    assign o_ready      = (state_q == S_IDLE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_dshot      = dshot_q;
    assign o_frame      = frame_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_dshot150_frame_encoder.sv
// Bench for dshot150_frame_encoder at scaled-down timing: frames are decoded from the
// pin by pulse width and compared against an arithmetic model of the DSHOT frame.
module tb_dshot150_frame_encoder;

    localparam int BIT = 48;
    localparam int T1H = 36;
    localparam int T0H = 18;
    localparam int GAP = 96;
    localparam int REP = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [10:0] thr = '0;
    logic        telem = 1'b0;
    logic        o_ready, o_dshot, o_busy, o_frame_done;
    logic [15:0] o_frame;

    int checks = 0;
    int failures = 0;

    dshot150_frame_encoder #(
        .BIT_CLKS(BIT), .T1H_CLKS(T1H), .T0H_CLKS(T0H),
        .GAP_CLKS(GAP), .REPEAT_CLKS(REP)
    ) dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
        .i_throttle(thr), .i_telem(telem), .o_dshot(o_dshot), .o_busy(o_busy),
        .o_frame(o_frame), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_frame(input int t, input int tel);
        int v, c;
        v = t * 2 + tel;
        c = (v ^ (v >> 4) ^ (v >> 8)) & 15;
        return 16'(v * 16 + c);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the sample right after the accepting edge.
    task automatic send(input int t, input int tel);
        @(negedge clk);
        thr   = 11'(t);
        telem = tel[0];
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_rise(input int max, output int waited, output bit ok);
        waited = 0;
        ok = 1'b0;
        while (waited < max) begin
            @(negedge clk);
            waited++;
            if (o_dshot === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Starts on the first high sample of a frame and decodes 16 bit periods.
    task automatic capture(output logic [15:0] f, output int werr);
        f = '0;
        werr = 0;
        for (int b = 0; b < 16; b++) begin
            int h;
            bit seen_low;
            h = 0;
            seen_low = 1'b0;
            for (int c = 0; c < BIT; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (o_dshot === 1'b1) begin
                    if (seen_low) werr++;
                    h++;
                end else begin
                    seen_low = 1'b1;
                end
            end
            if (h == T1H)      f = {f[14:0], 1'b1};
            else if (h == T0H) f = {f[14:0], 1'b0};
            else begin
                werr++;
                f = {f[14:0], 1'bx};
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [15:0] exp, output int end_idx);
        logic [15:0] got;
        int werr, n, dn, hi;
        checks++;
        if (o_dshot !== 1'b1) begin
            failures++;
            $display("FAIL %s latency: o_dshot=%b exp 1", name, o_dshot);
        end
        checks++;
        if (o_frame !== exp) begin
            failures++;
            $display("FAIL %s o_frame: got %h exp %h", name, o_frame, exp);
        end
        checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s busy/ready: busy=%b ready=%b exp 1/0", name, o_busy, o_ready);
        end
        capture(got, werr);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s pin_frame: got %h exp %h", name, got, exp);
        end
        checks++;
        if (werr != 0) begin
            failures++;
            $display("FAIL %s pulse_width: bad bits=%0d exp 0", name, werr);
        end
        @(negedge clk);
        checks++;
        if (o_frame_done !== 1'b1 || o_dshot !== 1'b0) begin
            failures++;
            $display("FAIL %s done_timing: done=%b dshot=%b exp 1/0", name, o_frame_done, o_dshot);
        end
        n = 1;
        dn = 0;
        hi = 0;
        while (n < GAP + 20) begin
            @(negedge clk);
            if (o_ready === 1'b1) break;
            n++;
            if (o_frame_done === 1'b1) dn++;
            if (o_dshot !== 1'b0) hi++;
        end
        checks++;
        if (n < GAP || n > GAP + 1 || hi != 0) begin
            failures++;
            $display("FAIL %s gap: busy cycles=%0d highs=%0d exp %0d..%0d/0", name, n, hi, GAP, GAP + 1);
        end
        checks++;
        if (dn != 0) begin
            failures++;
            $display("FAIL %s done_once: extra pulses=%0d exp 0", name, dn);
        end
        end_idx = 16 * BIT + n;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (o_dshot !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs: dshot=%b busy=%b done=%b exp 0/0/0", o_dshot, o_busy, o_frame_done);
        end
        checks++;
        if (o_frame !== 16'h0000 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_frame_ready: frame=%h ready=%b exp 0000/1", o_frame, o_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_dshot !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: ready=%b dshot=%b exp 1/0", o_ready, o_dshot);
        end
    endtask

    task automatic test_frames();
        int e, t, tel;
        int tv[3] = '{48, 1046, 0};
        int lv[3] = '{0, 0, 1};
        logic [15:0] fixed_exp[3] = '{16'h0606, 16'h82C6, 16'h0011};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (model_frame(tv[i], lv[i]) !== fixed_exp[i]) begin
                failures++;
                $display("FAIL model_vector%0d: got %h exp %h", i, model_frame(tv[i], lv[i]), fixed_exp[i]);
            end
            send(tv[i], lv[i]);
            check_frame("fixed", fixed_exp[i], e);
        end
        for (int i = 0; i < 5; i++) begin
            t = $urandom_range(2047);
            tel = $urandom_range(1);
            send(t, tel);
            check_frame("random", model_frame(t, tel), e);
        end
    endtask

    task automatic test_repeat();
        int e, w;
        bit ok;
        do_reset();
        send(48, 0);
        check_frame("rep_first", 16'h0606, e);
        for (int r = 0; r < 2; r++) begin
            wait_rise(REP + 50, w, ok);
            checks++;
            if (!ok || e + w != REP) begin
                failures++;
                $display("FAIL repeat_period: got %0d ok=%0d exp %0d", e + w, ok, REP);
            end
            check_frame("rep", 16'h0606, e);
        end
    endtask

    task automatic test_back_to_back();
        int e, w;
        bit ok;
        do_reset();
        send(48, 0);
        valid = 1'b1;
        thr   = 11'd1046;
        telem = 1'b0;
        repeat (5 * BIT) @(negedge clk);
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_ready: got %b exp 0", o_ready);
        end
        repeat (5 * BIT) @(negedge clk);
        do_capture_tail(e);
        wait_rise(5, w, ok);
        valid = 1'b0;
        checks++;
        if (!ok || w != 1) begin
            failures++;
            $display("FAIL b2b_accept: waited=%0d ok=%0d exp 1/1", w, ok);
        end
        check_frame("b2b_second", 16'h82C6, e);
    endtask

    // Finishes the 0x0606 frame already in flight (10 bits consumed by the caller).
    task automatic do_capture_tail(output int end_idx);
        int hi, n;
        hi = 0;
        n = 0;
        for (int c = 10 * BIT; c < 16 * BIT; c++) begin
            if (c >= 12 * BIT && c < 13 * BIT && o_dshot === 1'b1) hi++;
            @(negedge clk);
        end
        checks++;
        if (hi != T0H) begin
            failures++;
            $display("FAIL held_frame_bit3: high=%0d exp %0d", hi, T0H);
        end
        while (o_ready !== 1'b1 && n < GAP + 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < GAP - 1 || o_frame !== 16'h0606) begin
            failures++;
            $display("FAIL held_frame_gap: busy=%0d frame=%h exp >=%0d/0606", n, o_frame, GAP - 1);
        end
        end_idx = n;
    endtask

    task automatic test_reset_mid_frame();
        int hi;
        do_reset();
        send(1046, 0);
        repeat (8 * BIT + 5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_dshot !== 1'b0 || o_frame !== 16'h0000 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset: dshot=%b frame=%h ready=%b busy=%b exp 0/0000/1/0",
                     o_dshot, o_frame, o_ready, o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        for (int c = 0; c < 2 * REP + 100; c++) begin
            @(negedge clk);
            if (o_dshot !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL no_repeat_after_reset: high samples=%0d exp 0", hi);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_repeat();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dshot150_frame_encoder.md
Name: dshot150_frame_encoder

Overview:
Serialises one DSHOT150 motor command onto a single motor pin. It computes the CRC and generates the bit timing, with optional automatic frame repetition. It sits between the Wishbone DSHOT register block (upstream, base 0x0300), which hands it throttle/telemetry words, and the motor output mux feeding o_motor1..4 (downstream). One instance per motor.

Parameters:
BIT_CLKS, 480, clocks per bit period (6.667 us at 72 MHz).
T1H_CLKS, 360, high time for a '1' bit (5.0 us).
T0H_CLKS, 180, high time for a '0' bit (2.5 us).
GAP_CLKS, 960, minimum low time after the last bit before the next frame may start.
REPEAT_CLKS, 72000, frame start-to-start period for auto-repeat (1 ms); 0 disables auto-repeat.

Ports:
i_sys_clk  in  1  system clock, 72 MHz.
i_rst_n  in  1  asynchronous active-low reset.
i_valid  in  1  command request from the register block.
o_ready  out  1  encoder can accept a command; high only in IDLE.
i_throttle  in  11  DSHOT value: 0 = disarmed, 1-47 = special commands, 48-2047 = throttle.
i_telem  in  1  telemetry request bit.
o_dshot  out  1  serial output to the motor mux; idles low.
o_busy  out  1  high while in HIGH, LOW or GAP.
o_frame  out  16  last frame latched for transmission, for register readback.
o_frame_done  out  1  one-cycle pulse when the last bit period ends.

Behaviour:
- Reset (async, i_rst_n=0):
  - Outputs: o_dshot=0, o_busy=0, o_frame_done=0, o_frame=0, o_ready=1.
  - State goes to IDLE, repeat is disarmed and all counters clear.
  - Reset mid-frame forces o_dshot low immediately; the partial frame is abandoned, not resumed.
- Frame construction (combinational on input):
  - v[11:0] = {i_throttle, i_telem}.
  - crc = (v ^ (v>>4) ^ (v>>8)) & 4'hF.
  - frame = {v, crc}.
  - On accept, frame is latched into o_frame and a 16-bit shift register.
- Handshake:
  - Accept when i_valid && o_ready at a rising edge.
  - i_throttle/i_telem are sampled only on that edge; later changes do not affect the frame in flight.
- States:
  - IDLE:
    - Accept → HIGH.
    - Else if repeat is armed and the period counter >= REPEAT_CLKS-1 → HIGH, resending o_frame.
    - A new accept has priority over a repeat in the same cycle.
    - The first accept arms repeat (when REPEAT_CLKS>0).
  - HIGH/LOW (one bit period):
    - The bit counter runs 0..BIT_CLKS-1.
    - o_dshot=1 while bit counter < (current bit ? T1H_CLKS : T0H_CLKS); else 0.
    - Bits go out MSB first, frame[15] first.
    - At bit counter = BIT_CLKS-1, shift to the next bit.
    - After bit 0, pulse o_frame_done and go to GAP.
  - GAP: o_dshot=0 for GAP_CLKS clocks → IDLE.
- Timing:
  - o_dshot rises on the cycle after acceptance (latency 1 clock).
  - Frame length is 16*BIT_CLKS clocks.
- Period counter:
  - Clears at each frame start, counts every clock, saturates at REPEAT_CLKS-1.
  - With GAP_CLKS + 16*BIT_CLKS > REPEAT_CLKS, repeats occur back-to-back, each after a full GAP.
- o_dshot is registered; no combinational path from inputs to o_dshot.
- o_ready = (state==IDLE); o_busy = !o_ready.
- Counters are wide enough for max(REPEAT_CLKS, GAP_CLKS, BIT_CLKS).
- Parameter check: T0H_CLKS < T1H_CLKS < BIT_CLKS, enforced by elaboration-time check.

Test Plan:
- Throttle 48, telem 0 → o_frame=0x0606; 16 pulses decoded MSB-first = 0x0606; '0' highs 2500 ns ±14 ns, '1' highs 5000 ns ±14 ns; bit period 6667 ns.
- Throttle 1046, telem 0 → o_frame=0x82C6 on the pin; o_frame_done pulses once, 16*480 clocks after the first rising edge.
- Throttle 0, telem 1 → frame 0x0011.
- Auto-repeat: single command of 48, REPEAT_CLKS=72000 → frame starts every 72000 clocks, identical 0x0606.
- Command update during a frame:
  - During a frame, hold i_valid with throttle 1046 → o_ready=0; no accept until IDLE.
  - Then the next frame is 0x82C6, not a repeat.
  - Line stays low ≥ GAP_CLKS between frames.
- Async reset mid-frame (after bit 7):
  - o_dshot=0 within the same time step; o_frame=0, o_ready=1.
  - No repeat occurs until a new command is accepted.
